mux_lut_cfg: RTL and testbench
==============================

Name: mux_lut_cfg

Overview:
- Parametrised, run-time-configurable look-up-table cell built only from 2:1 mux instances and constant/register data inputs.
- Generalises the fixed "gate from mux + constants" idea to any N_IN-input boolean function.
- The truth table is loaded serially over a ready/valid config port, committed atomically, then evaluated on a pipelined ready/valid data path.
- Used as the generic programmable-logic leaf in the combinational-logic exercise tree.

Parameters:
- N_IN, 2, number of function inputs (1..6); table depth TBL = 2**N_IN bits.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_start  input  1  pulse: begin (or restart) a table load.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  next truth-table bit, index 0 first.
- cfg_ready  output  1  block accepts a config bit (high only in LOAD).
- cfg_done  output  1  one-cycle pulse: new table committed.
- in_valid  input  1  in is valid.
- in  input  N_IN  function input vector; used as the table index.
- in_ready  output  1  block accepts input (high only in RUN).
- out_valid  output  1  out is valid (one-cycle pulse per accepted input).
- out  output  1  registered function value.

Behaviour:
- State: RUN and LOAD. Reset -> RUN.
- Reset values: table = default inverter (bit k = ~k[0], i.e. out = ~in[0]); shadow = 0; count = 0; out = 0; out_valid = 0; cfg_done = 0.
- Handshakes: in_ready = (state==RUN); cfg_ready = (state==LOAD).
- RUN: accept when in_valid & in_ready. Next cycle out = table[in] and out_valid = 1. Latency is exactly 1 cycle; throughput is 1 per cycle. With no accept, out_valid = 0 and out holds its last value.
- Evaluation path: a binary tree of 2:1 muxes, N_IN levels, with in[0] selecting at the leaf level. No behavioural indexing.
- RUN + cfg_start:
  - Go to LOAD next cycle; count = 0; shadow cleared.
  - An input accepted in the same cycle uses the old table, and its out_valid still appears next cycle.
- LOAD:
  - Each cfg_valid & cfg_ready writes shadow[count] = cfg_bit and increments count. cfg_valid low is a bubble; nothing changes.
  - On the accept where count == TBL-1: table <= shadow with the final bit applied, state -> RUN, cfg_done = 1 for one cycle, count -> 0.
  - in_valid is ignored (in_ready = 0); out_valid = 0.
- LOAD + cfg_start: restart. count = 0, partial shadow discarded, and any cfg bit in the same cycle is ignored. The table is unchanged until a full load completes.
- Atomic commit: the active table is never partially updated.
- rst during LOAD: partial load discarded; table returns to the default inverter; state = RUN.
- The first input accepted after cfg_done uses the new table.
- count width = N_IN+1 bits; no wrap beyond TBL-1.

Test Plan:
- Reset, N_IN=2; apply in = 0,1,2,3 back-to-back -> out = 1,0,1,0 one cycle after each; out_valid high 4 consecutive cycles.
- cfg_start; cfg_bit stream 0,0,0,1 (AND) -> cfg_done pulses one cycle after the 4th accept, then in_ready = 1; in=3 -> out=1, in=2 -> out=0.
- Load XOR (0,1,1,0) with cfg_valid low between each bit -> identical commit, cfg_done once; in=1 -> 1, in=3 -> 0.
- Mid-load restart: 2 bits of 1,1 then cfg_start, then 0,1,1,1 (OR) -> table = OR; in=0 -> out=0, in=2 -> out=1.
- rst after 3 of 4 bits of a load -> state RUN, in=0 -> out=1, in=1 -> out=0 (default inverter).
- in_valid with in=1 in the same cycle as cfg_start under the AND table -> out=0 next cycle with out_valid=1; in_ready = 0 from the following cycle.

Source files
------------

// File: rtl/mux_lut_cfg.sv
// Run-time configurable N_IN-input LUT cell: a 2:1 mux tree evaluates the
// active table, which is reloaded serially and committed atomically.

module mux_lut_cfg_mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    assign y = s ? b : a;
endmodule

module mux_lut_cfg #(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in,
    output logic            in_ready,
    output logic            out_valid,
    output logic            out
);
    localparam int TBL = 2**N_IN;
    localparam logic [N_IN:0]  LAST_IDX    = (N_IN+1)'(TBL-1);
    // Default table makes the cell an inverter of in[0].
    localparam logic [TBL-1:0] DEFAULT_TBL = {(TBL/2){2'b01}};

    typedef enum logic {RUN, LOAD} state_t;

    state_t          state_q;
    logic [TBL-1:0]  tbl_q;
    logic [TBL-1:0]  shadow_q;
    logic [TBL-1:0]  shadow_wr;
    logic [N_IN:0]   count_q;
    logic            lut_value;

    assign in_ready  = (state_q == RUN);
    assign cfg_ready = (state_q == LOAD);

    // Level l halves the candidate set using in[l]; level 0 reads the table.
    for (genvar l = 0; l < N_IN; l++) begin : g_lvl
        logic [(TBL>>l)-1:0]     src;
        logic [(TBL>>(l+1))-1:0] y;
        if (l == 0) begin : g_leaf
            assign src = tbl_q;
        end else begin : g_inner
            assign src = g_lvl[l-1].y;
        end
        for (genvar j = 0; j < (TBL>>(l+1)); j++) begin : g_mux
            mux_lut_cfg_mux2 u_mux (
                .a (src[2*j]),
                .b (src[2*j+1]),
                .s (in[l]),
                .y (y[j])
            );
        end
    end
    assign lut_value = g_lvl[N_IN-1].y[0];

    // NOTE: default-assign first so every path writes shadow_wr and no latch is inferred.
    always_comb begin
        shadow_wr = shadow_q;
        shadow_wr[count_q[N_IN-1:0]] = cfg_bit;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            tbl_q     <= DEFAULT_TBL;
            shadow_q  <= '0;
            count_q   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            cfg_done  <= 1'b0;
            case (state_q)
                RUN: begin
                    // An input accepted alongside cfg_start still sees the old table.
                    if (in_valid) begin
                        out       <= lut_value;
                        out_valid <= 1'b1;
                    end
                    if (cfg_start) begin
                        state_q  <= LOAD;
                        count_q  <= '0;
                        shadow_q <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        count_q  <= '0;
                        shadow_q <= '0;
                    end else if (cfg_valid) begin
                        if (count_q == LAST_IDX) begin
                            tbl_q    <= shadow_wr;
                            state_q  <= RUN;
                            cfg_done <= 1'b1;
                            count_q  <= '0;
                        end else begin
                            shadow_q <= shadow_wr;
                            count_q  <= count_q + 1'b1;
                        end
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_lut_cfg.sv
// Directed bench for mux_lut_cfg (N_IN=2): expected outputs are queued by the
// stimulus process and popped by an independent monitor on out_valid.

module tb_mux_lut_cfg;
    localparam int N_IN = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_ready;
    logic            cfg_done;
    logic            in_valid;
    logic [N_IN-1:0] in_v;
    logic            in_ready;
    logic            out_valid;
    logic            out;

    int tests  = 0;
    int failed = 0;
    logic exp_q[$];

    mux_lut_cfg #(.N_IN(N_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in        (in_v),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every out_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                logic e;
                e = exp_q.pop_front();
                check("out", {31'd0, out}, {31'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N_IN-1:0] v, input logic exp);
        in_valid = 1'b1;
        in_v     = v;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("load_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("load_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    // Shift bits[0..n-1]; a full table commit is expected on the 4th bit.
    task automatic shift_bits(input logic [3:0] bits, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = bits[i];
            tick();
            cfg_valid = 1'b0;
            if (i == 3) begin
                check("cfg_done_pulse", {31'd0, cfg_done}, 32'd1);
                check("run_in_ready", {31'd0, in_ready}, 32'd1);
                check("run_cfg_ready", {31'd0, cfg_ready}, 32'd0);
            end else begin
                check("cfg_done_early", {31'd0, cfg_done}, 32'd0);
            end
            if (gaps && i != 3) begin
                tick();
                check("cfg_done_bubble", {31'd0, cfg_done}, 32'd0);
            end
        end
    endtask

    task automatic load(input logic [3:0] bits, input bit gaps);
        start_load();
        shift_bits(bits, 4, gaps);
        tick();
        check("cfg_done_one_cycle", {31'd0, cfg_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        in_valid = 1'b0; in_v = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {31'd0, out}, 32'd0);
        check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);

        // Default inverter, back-to-back
        send(2'd0, 1'b1); send(2'd1, 1'b0); send(2'd2, 1'b1); send(2'd3, 1'b0);
        tick();

        // AND table
        load(4'b1000, 1'b0);
        send(2'd3, 1'b1); send(2'd2, 1'b0);

        // XOR with bubbles between bits
        load(4'b0110, 1'b1);
        send(2'd1, 1'b1); send(2'd3, 1'b0);

        // Mid-load restart, then OR
        start_load();
        shift_bits(4'b0011, 2, 1'b0);
        start_load();
        shift_bits(4'b1110, 4, 1'b0);
        tick();
        send(2'd0, 1'b0); send(2'd2, 1'b1);

        // Reset after 3 of 4 bits restores the default inverter
        start_load();
        shift_bits(4'b1000, 3, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_load_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_load_cfg_done", {31'd0, cfg_done}, 32'd0);
        send(2'd0, 1'b1); send(2'd1, 1'b0);

        // Input accepted in the same cycle as cfg_start uses the old (AND) table
        load(4'b1000, 1'b0);
        cfg_start = 1'b1;
        in_valid  = 1'b1;
        in_v      = 2'd1;
        exp_q.push_back(1'b0);
        tick();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        check("same_cycle_in_ready", {31'd0, in_ready}, 32'd0);
        // in_valid during LOAD must not produce output
        in_valid = 1'b1;
        in_v     = 2'd3;
        tick();
        in_valid = 1'b0;
        shift_bits(4'b1000, 4, 1'b0);
        send(2'd3, 1'b1);
        tick(); tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
